branch_predict_unit: RTL and testbench

//  Successor to the single-cycle branch decision logic. Resolves RV32I conditional

---
 rtl/riscv_pkg.sv | 16 +
 rtl/branch_compare.sv | 36 +++
 rtl/branch_predict_unit.sv | 111 +++++++++++
 tb/tb_branch_predict_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I branch funct3 encodings and BHT counter types
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int BHT_CNT_W = 2;
  typedef logic [BHT_CNT_W-1:0] bht_cnt_t;
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam bht_cnt_t BHT_CNT_RESET = {1'b0, {(BHT_CNT_W-1){1'b1}}};

endpackage

// File: rtl/branch_compare.sv
// rtl/branch_compare.sv - combinational RV32I branch condition evaluation from full operands
module branch_compare
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (rs1_i == rs2_i);
  assign lt  = ($signed(rs1_i) < $signed(rs2_i));
  assign ltu = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = ~eq;
      F3_BLT:  taken_o = lt;
      F3_BGE:  taken_o = ~lt;
      F3_BLTU: taken_o = ltu;
      F3_BGEU: taken_o = ~ltu;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BHT branch predictor with resolve/train port
// Optional performance counters enabled by defining BRANCH_STATS_EN.
module branch_predict_unit
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = BHT_CNT_W,
  parameter int STAT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pred_valid_i,
  input  logic [XLEN-1:0]   pred_pc_i,
  output logic              pred_valid_o,
  output logic              pred_taken_o,
  input  logic              res_valid_i,
  input  logic [XLEN-1:0]   res_pc_i,
  input  logic [2:0]        res_funct3_i,
  input  logic [XLEN-1:0]   res_rs1_i,
  input  logic [XLEN-1:0]   res_rs2_i,
  input  logic              res_pred_taken_i,
  output logic              branch_taken_o,
  output logic              mispredict_o,
  output logic              illegal_o,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispred_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_RESET = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bht_q [BHT_ENTRIES];
  logic [CNT_W-1:0] cnt_d;
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             cmp_taken;
  logic             cmp_illegal;
  logic             res_legal;
  logic             pred_valid_q;
  logic             pred_taken_q;

  // Word-aligned PCs: bits [1:0] and everything above the index are not used.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0],
                            res_pc_i[XLEN-1:IDX_W+2], res_pc_i[1:0]};

  assign pred_idx = pred_pc_i[IDX_W+1:2];
  assign res_idx  = res_pc_i[IDX_W+1:2];

  branch_compare #(.XLEN(XLEN)) u_branch_compare (
    .funct3_i  (res_funct3_i),
    .rs1_i     (res_rs1_i),
    .rs2_i     (res_rs2_i),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  assign res_legal      = res_valid_i & ~cmp_illegal;
  assign branch_taken_o = res_legal & cmp_taken;
  assign mispredict_o   = res_legal & (cmp_taken != res_pred_taken_i);
  assign illegal_o      = res_valid_i & cmp_illegal;

  always_comb begin
    cnt_d = bht_q[res_idx];
    if (cmp_taken) begin
      if (bht_q[res_idx] != CNT_MAX) cnt_d = bht_q[res_idx] + 1'b1;
    end else begin
      if (bht_q[res_idx] != '0) cnt_d = bht_q[res_idx] - 1'b1;
    end
  end

  // Lookup samples bht_q before this edge's update lands: read-before-write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_RESET;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
    end else begin
      if (res_legal) bht_q[res_idx] <= cnt_d;
      pred_valid_q <= pred_valid_i;
      pred_taken_q <= pred_valid_i & bht_q[pred_idx][CNT_W-1];
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q;
  logic [STAT_W-1:0] stat_mispred_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (res_legal && (stat_branches_q != '1)) stat_branches_q <= stat_branches_q + 1'b1;
      if (mispredict_o && (stat_mispred_q != '1)) stat_mispred_q <= stat_mispred_q + 1'b1;
    end
  end

  assign stat_branches_o = stat_branches_q;
  assign stat_mispred_o  = stat_mispred_q;
`else
  assign stat_branches_o = '0;
  assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pred_valid_i = 1'b0;
  logic [31:0] pred_pc_i = '0;
  logic        pred_valid_o;
  logic        pred_taken_o;
  logic        res_valid_i = 1'b0;
  logic [31:0] res_pc_i = '0;
  logic [2:0]  res_funct3_i = '0;
  logic [31:0] res_rs1_i = '0;
  logic [31:0] res_rs2_i = '0;
  logic        res_pred_taken_i = 1'b0;
  logic        branch_taken_o;
  logic        mispredict_o;
  logic        illegal_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic sb_q [$];
  int   model_cnt [64];
  int   exp_br = 0;
  int   exp_mp = 0;

  always #5 clk_i = ~clk_i;

  branch_predict_unit dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pred_valid_i     (pred_valid_i),
    .pred_pc_i        (pred_pc_i),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .res_valid_i      (res_valid_i),
    .res_pc_i         (res_pc_i),
    .res_funct3_i     (res_funct3_i),
    .res_rs1_i        (res_rs1_i),
    .res_rs2_i        (res_rs2_i),
    .res_pred_taken_i (res_pred_taken_i),
    .branch_taken_o   (branch_taken_o),
    .mispredict_o     (mispredict_o),
    .illegal_o        (illegal_o),
    .stat_branches_o  (stat_branches_o),
    .stat_mispred_o   (stat_mispred_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%08h exp=0x%08h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic int exp_stat(input int v);
`ifdef BRANCH_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    foreach (model_cnt[i]) model_cnt[i] = 1;
    exp_br = 0;
    exp_mp = 0;
  endtask

  // Predictions leave the DUT one cycle after the request; compare against the scoreboard.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (pred_valid_o === 1'b1) begin
        if (sb_q.size() == 0) check_eq("pred_unexpected", pred_valid_o, 32'd0);
        else check_eq("pred_taken", pred_taken_o, sb_q.pop_front());
      end else begin
        check_eq("pred_valid_idle", pred_valid_o, 32'd0);
        check_eq("pred_taken_idle", pred_taken_o, 32'd0);
      end
    end
  end

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic rv,
                       input logic [31:0] rpc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic rpred);
    logic legal, tk;
    pred_valid_i = pv; pred_pc_i = ppc;
    res_valid_i = rv; res_pc_i = rpc; res_funct3_i = f3;
    res_rs1_i = a; res_rs2_i = b; res_pred_taken_i = rpred;
    #1;
    legal = rv && (f3 != 3'b010) && (f3 != 3'b011);
    tk    = legal && ref_taken(f3, a, b);
    check_eq("branch_taken", branch_taken_o, tk);
    check_eq("mispredict", mispredict_o, legal && (tk != rpred));
    check_eq("illegal", illegal_o, rv && !legal);
    check_eq("stat_branches", stat_branches_o, exp_stat(exp_br));
    check_eq("stat_mispred", stat_mispred_o, exp_stat(exp_mp));
    if (pv) sb_q.push_back(model_cnt[idx_of(ppc)] >= 2);
    if (legal) begin
      if (tk && model_cnt[idx_of(rpc)] < 3) model_cnt[idx_of(rpc)]++;
      if (!tk && model_cnt[idx_of(rpc)] > 0) model_cnt[idx_of(rpc)]--;
      exp_br++;
      if (tk != rpred) exp_mp++;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, '0, 3'b000, '0, '0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic rpred);
    drive(1'b0, '0, 1'b1, pc, f3, a, b, rpred);
  endtask

  // One reset cycle with a live request and resolve that must both be dropped.
  task automatic do_reset();
    rst_i = 1'b1;
    pred_valid_i = 1'b1; pred_pc_i = 32'h100;
    res_valid_i = 1'b1; res_pc_i = 32'h100; res_funct3_i = 3'b000;
    res_rs1_i = '0; res_rs2_i = '0; res_pred_taken_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    pred_valid_i = 1'b0; res_valid_i = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    do_reset();
    mon_en = 1'b1;
    check_eq("rst_pred_valid", pred_valid_o, 32'd0);
    check_eq("rst_pred_taken", pred_taken_o, 32'd0);
    check_eq("rst_stat_br", stat_branches_o, 32'd0);
    check_eq("rst_stat_mp", stat_mispred_o, 32'd0);

    // Fresh entry predicts not-taken.
    lookup(32'h100);
    // BLT signed: -1 < 1 taken, mispredicted against pred=0.
    resolve(32'h100, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0);
    lookup(32'h100);
    // BLTU: 0xFFFFFFFF < 1 unsigned is false; drive to 0 and beyond without wrap.
    resolve(32'h100, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1);
    repeat (4) resolve(32'h100, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b0);
    resolve(32'h100, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0);
    lookup(32'h100);
    // Same-cycle lookup and taken resolve at 0x200 returns the pre-update value.
    drive(1'b1, 32'h200, 1'b1, 32'h200, 3'b000, 32'd7, 32'd7, 1'b0);
    lookup(32'h200);
    // Saturate at max: several taken resolves then a not-taken still predicts taken.
    repeat (4) resolve(32'h300, 3'b001, 32'd1, 32'd2, 1'b1);
    resolve(32'h300, 3'b001, 32'd5, 32'd5, 1'b1);
    lookup(32'h300);
    // Illegal funct3 values leave BHT and stats untouched.
    resolve(32'h200, 3'b010, 32'd1, 32'd1, 1'b0);
    resolve(32'h200, 3'b011, 32'd1, 32'd2, 1'b1);
    lookup(32'h200);

    // Mixed random traffic over a handful of entries.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7)) * 4,
            1'($urandom_range(0, 1)), 32'h100 + 32'($urandom_range(0, 7)) * 4, f3,
            32'($urandom_range(0, 3)) - 32'd1, 32'($urandom_range(0, 3)) - 32'd1,
            1'($urandom_range(0, 1)));
    end
    drive(1'b0, '0, 1'b0, '0, 3'b000, '0, '0, 1'b0);

    do_reset();
    check_eq("rst2_stat_br", stat_branches_o, 32'd0);
    check_eq("rst2_stat_mp", stat_mispred_o, 32'd0);
    for (int i = 0; i < 64; i++) lookup(32'(i * 4));

    // Ten resolves, three mispredicted.
    for (int i = 0; i < 10; i++) resolve(32'h40, 3'b000, 32'd3, 32'd3, (i < 3) ? 1'b0 : 1'b1);
    drive(1'b0, '0, 1'b0, '0, 3'b000, '0, '0, 1'b0);
    check_eq("stat_br_10", stat_branches_o, 32'(exp_stat(10)));
    check_eq("stat_mp_3", stat_mispred_o, 32'(exp_stat(3)));

    @(negedge clk_i); #1;
    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
